// File: rtl/qsys_sample_buffer_pkg.sv
// Shared types and constants for the sample buffer writer: FSM states,
// word geometry and Avalon byte-enable patterns.
package qsys_sample_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int         BYTES_PER_WORD   = 4;
  localparam int         SAMPLES_PER_WORD = 2;
  localparam logic [3:0] BE_FULL          = 4'b1111;
  localparam logic [3:0] BE_LOW           = 4'b0011;

endpackage

// File: rtl/qsys_sample_buffer_writer_if.sv
// Sample stream (valid/ready) plus Avalon-MM write channel between the ADC
// front end, the buffer writer and the sample RAM slave port.
interface qsys_sample_buffer_writer_if #(
  parameter int ADDR_W = 32
);
  logic [15:0]       sample_data;
  logic              sample_valid;
  logic              sample_ready;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;

  modport master (
    input  sample_data, sample_valid, avm_waitrequest,
    output sample_ready, avm_address, avm_write, avm_writedata, avm_byteenable
  );

  modport slave (
    output sample_data, sample_valid, avm_waitrequest,
    input  sample_ready, avm_address, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/sample_word_packer.sv
// Packs accepted 16-bit samples into a 32-bit word, earlier sample in the low
// half; flags a word that carries only a final odd sample.
module sample_word_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        accept,
  input  logic        last_sample,
  input  logic [15:0] sample,
  output logic [31:0] word,
  output logic        word_done,
  output logic        odd
);
  logic        half_q;
  logic        odd_q;
  logic [31:0] word_q;

  assign word_done = accept && (half_q || last_sample);
  assign word      = word_q;
  assign odd       = odd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_q <= 1'b0;
      odd_q  <= 1'b0;
      word_q <= '0;
    end else if (accept) begin
      if (!half_q) begin
        // Upper half cleared so a lone final sample goes out zero-padded
        word_q <= {16'h0000, sample};
        odd_q  <= last_sample;
        half_q <= !last_sample;
      end else begin
        word_q[31:16] <= sample;
        odd_q         <= 1'b0;
        half_q        <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/qsys_sample_buffer_writer.sv
// Avalon-MM write master filling the sample RAM with packed 16-bit samples
// from a byte base address, then pulsing done.
module qsys_sample_buffer_writer
  import qsys_sample_buffer_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 5120,
  parameter int CNT_W       = 14
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [CNT_W-1:0]           num_samples,
  qsys_sample_buffer_writer_if.master bus,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);
  localparam logic [CNT_W:0] MAX_SAMPLES = (CNT_W+1)'(SAMPLES_PER_WORD * DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic              cfg_err_q;
  logic              too_big, accept, last_sample, write_ack;
  logic              word_done, word_odd;
  logic [31:0]       word;
  logic [CNT_W-1:0]  word_samples;

  assign too_big      = {1'b0, num_samples} > MAX_SAMPLES;
  assign accept       = (state_q == COLLECT) && bus.sample_valid;
  assign last_sample  = remaining_q == CNT_W'(1);
  assign write_ack    = (state_q == WRITE) && !bus.avm_waitrequest;
  assign word_samples = word_odd ? CNT_W'(1) : CNT_W'(SAMPLES_PER_WORD);

  sample_word_packer u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .accept      (accept),
    .last_sample (last_sample),
    .sample      (bus.sample_data),
    .word        (word),
    .word_done   (word_done),
    .odd         (word_odd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_samples == '0) state_d = DONE;
          else if (!too_big)     state_d = COLLECT;
        end
      end
      COLLECT: if (word_done) state_d = WRITE;
      WRITE: begin
        if (!bus.avm_waitrequest)
          state_d = (remaining_q <= word_samples) ? DONE : COLLECT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.sample_ready   = 1'b0;
    bus.avm_write      = 1'b0;
    bus.avm_byteenable = '0;
    busy               = 1'b1;
    done               = 1'b0;
    case (state_q)
      IDLE:    busy = 1'b0;
      COLLECT: bus.sample_ready = 1'b1;
      WRITE: begin
        bus.avm_write      = 1'b1;
        bus.avm_byteenable = word_odd ? BE_LOW : BE_FULL;
      end
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign bus.avm_address   = addr_q;
  assign bus.avm_writedata = word;
  assign cfg_err           = cfg_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= (state_q == IDLE) && start && too_big;
      if ((state_q == IDLE) && start && !too_big && (num_samples != '0)) begin
        // Low address bits masked so every write stays word aligned
        addr_q      <= base_addr & ~ADDR_W'(BYTES_PER_WORD - 1);
        remaining_q <= num_samples;
      end else if (write_ack) begin
        addr_q      <= addr_q + ADDR_W'(BYTES_PER_WORD);
        remaining_q <= remaining_q - word_samples;
      end
    end
  end
endmodule
